// File: rtl/multiplication_result_buffer_if.sv
// rtl/multiplication_result_buffer_if.sv - issue, product and writeback signals of the multiply result buffer
interface multiplication_result_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                  clk_en_i;
  logic                  issue_valid_i;
  logic [TAG_WIDTH-1:0]  issue_tag_i;
  logic                  issue_ready_o;
  logic                  issue_fire_o;
  logic [DATA_WIDTH-1:0] product_i;
  logic                  product_valid_i;
  logic                  flush_i;
  logic                  wb_valid_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [TAG_WIDTH-1:0]  wb_tag_o;
  logic                  wb_ready_i;
  logic                  align_error_o;

  modport slave (
    input  clk_en_i, issue_valid_i, issue_tag_i, product_i, product_valid_i, flush_i, wb_ready_i,
    output issue_ready_o, issue_fire_o, wb_valid_o, wb_data_o, wb_tag_o, align_error_o
  );

  modport master (
    output clk_en_i, issue_valid_i, issue_tag_i, product_i, product_valid_i, flush_i, wb_ready_i,
    input  issue_ready_o, issue_fire_o, wb_valid_o, wb_data_o, wb_tag_o, align_error_o
  );
endinterface

// File: rtl/multiplication_result_buffer.sv
// rtl/multiplication_result_buffer.sv - tag pipe, credit throttle and result FIFO behind the multiplier
// MUL_LATENCY must be >= 2 and DEPTH a power of two >= 2.
module multiplication_result_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 6,
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 4
) (
  input logic                           clk_i,
  input logic                           rst_i,
  multiplication_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(MUL_LATENCY + 1);
  localparam int CW = $clog2(DEPTH + MUL_LATENCY + 1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic                  align_err_q, align_err_d;
  logic [MUL_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [MUL_LATENCY-1:0] pipe_kill_q, pipe_kill_d;
  logic [TAG_WIDTH-1:0]  pipe_tag_q [MUL_LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag_d [MUL_LATENCY];

  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag_q  [DEPTH];

  logic [PW-1:0]         count;
  logic [CW-1:0]         credit_used;
  logic                  full;
  logic                  empty;
  logic                  issue_ready;
  logic                  fire;
  logic                  tail_vld;
  logic                  tail_kill;
  logic [TAG_WIDTH-1:0]  tail_tag;
  logic                  enq;
  logic                  deq;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // Credit counts products still in the multiplier so every arrival is guaranteed a slot.
  assign credit_used = CW'(count) + CW'(inflight_q);
  assign issue_ready = bus.clk_en_i & ~bus.flush_i & (credit_used < CW'(DEPTH));
  assign fire        = bus.issue_valid_i & issue_ready;

  assign tail_vld  = pipe_vld_q[MUL_LATENCY-1];
  assign tail_kill = pipe_kill_q[MUL_LATENCY-1];
  assign tail_tag  = pipe_tag_q[MUL_LATENCY-1];

  assign bus.issue_ready_o = issue_ready;
  assign bus.issue_fire_o  = fire;
  assign bus.wb_valid_o    = ~empty;
  assign bus.wb_data_o     = empty ? '0 : mem_data_q[rd_ptr_q[AW-1:0]];
  assign bus.wb_tag_o      = empty ? '0 : mem_tag_q[rd_ptr_q[AW-1:0]];
  assign bus.align_error_o = align_err_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = inflight_q;
    align_err_d = align_err_q;
    pipe_vld_d  = pipe_vld_q;
    pipe_kill_d = pipe_kill_q;
    pipe_tag_d  = pipe_tag_q;
    enq         = 1'b0;
    deq         = 1'b0;

    if (bus.clk_en_i) begin
      pipe_vld_d     = {pipe_vld_q[MUL_LATENCY-2:0], fire};
      pipe_kill_d[0] = 1'b0;
      pipe_tag_d[0]  = bus.issue_tag_i;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        pipe_kill_d[i] = pipe_kill_q[i-1] | bus.flush_i;
        pipe_tag_d[i]  = pipe_tag_q[i-1];
      end

      if (bus.product_valid_i != tail_vld) begin
        align_err_d = 1'b1;
      end else if (tail_vld && !tail_kill && !bus.flush_i) begin
        if (full) align_err_d = 1'b1;
        else      enq = 1'b1;
      end

      deq = ~empty & bus.wb_ready_i & ~bus.flush_i;

      if (bus.flush_i) begin
        rd_ptr_d = wr_ptr_q;
      end else begin
        if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      end

      // Killed ops still return their credit when they leave the tail.
      case ({fire, tail_vld})
        2'b10:   inflight_d = inflight_q + IW'(1);
        2'b01:   inflight_d = inflight_q - IW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= '0;
      align_err_q <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_kill_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) pipe_tag_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      align_err_q <= align_err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_kill_q <= pipe_kill_d;
      pipe_tag_q  <= pipe_tag_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= bus.product_i;
      mem_tag_q[wr_ptr_q[AW-1:0]]  <= tail_tag;
    end
  end
endmodule
